// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice allocator with retrigger, free-voice and oldest-voice stealing
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int FCW_W      = 32,
  parameter int AGE_W      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ev_valid,
  output logic                        ev_ready,
  input  logic                        ev_on,
  input  logic [6:0]                  ev_note,
  input  logic [FCW_W-1:0]            ev_fcw,
  output logic [NUM_VOICES*FCW_W-1:0] voice_fcw,
  output logic [NUM_VOICES-1:0]       voice_gate,
  output logic [NUM_VOICES-1:0]       voice_trig,
  output logic                        steal
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic {IDLE, DECIDE} state_t;

  state_t                  state_q, state_d;
  logic                    lat_on_q, lat_on_d;
  logic [6:0]              lat_note_q, lat_note_d;
  logic [FCW_W-1:0]        lat_fcw_q, lat_fcw_d;

  logic [FCW_W-1:0]        vfcw_q  [NUM_VOICES];
  logic [FCW_W-1:0]        vfcw_d  [NUM_VOICES];
  logic [6:0]              vnote_q [NUM_VOICES];
  logic [6:0]              vnote_d [NUM_VOICES];
  logic [AGE_W-1:0]        vage_q  [NUM_VOICES];
  logic [AGE_W-1:0]        vage_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0]   gate_q, gate_d;
  logic [NUM_VOICES-1:0]   trig_q, trig_d;
  logic                    steal_q, steal_d;

  logic                    hit_found, free_found;
  logic [IDX_W-1:0]        hit_idx, free_idx, old_idx, tgt_idx;
  logic [AGE_W-1:0]        old_age;

  assign ev_ready   = (state_q == IDLE);
  assign voice_gate = gate_q;
  assign voice_trig = trig_q;
  assign steal      = steal_q;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_fcw[g*FCW_W +: FCW_W] = vfcw_q[g];
  end

  // Target selection: retrigger match first, then lowest free voice, then oldest voice
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (gate_q[i] && (vnote_q[i] == lat_note_q)) begin
        hit_found = 1'b1;
        hit_idx   = i[IDX_W-1:0];
      end
      if (!gate_q[i]) begin
        free_found = 1'b1;
        free_idx   = i[IDX_W-1:0];
      end
    end
    old_idx = '0;
    old_age = vage_q[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (vage_q[i] > old_age) begin
        old_age = vage_q[i];
        old_idx = i[IDX_W-1:0];
      end
    end
    if (hit_found)       tgt_idx = hit_idx;
    else if (free_found) tgt_idx = free_idx;
    else                 tgt_idx = old_idx;
  end

  // FSM next state, event latch and voice table commit during DECIDE
  always_comb begin
    state_d    = state_q;
    lat_on_d   = lat_on_q;
    lat_note_d = lat_note_q;
    lat_fcw_d  = lat_fcw_q;
    vfcw_d     = vfcw_q;
    vnote_d    = vnote_q;
    vage_d     = vage_q;
    gate_d     = gate_q;
    trig_d     = '0;
    steal_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev_valid) begin
          state_d    = DECIDE;
          lat_on_d   = ev_on;
          lat_note_d = ev_note;
          lat_fcw_d  = ev_fcw;
        end
      end
      DECIDE: begin
        state_d = IDLE;
        if (lat_on_q) begin
          steal_d         = !hit_found && !free_found;
          trig_d[tgt_idx] = 1'b1;
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (tgt_idx == i[IDX_W-1:0]) begin
              vfcw_d[i]  = lat_fcw_q;
              vnote_d[i] = lat_note_q;
              vage_d[i]  = '0;
              gate_d[i]  = 1'b1;
            end else if (gate_q[i] && (vage_q[i] != AGE_MAX)) begin
              vage_d[i] = vage_q[i] + AGE_ONE;
            end
          end
        end else begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (gate_q[i] && (vnote_q[i] == lat_note_q)) gate_d[i] = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset that also drops any pending event
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_on_q   <= 1'b0;
      lat_note_q <= '0;
      lat_fcw_q  <= '0;
      vfcw_q     <= '{default: '0};
      vnote_q    <= '{default: '0};
      vage_q     <= '{default: '0};
      gate_q     <= '0;
      trig_q     <= '0;
      steal_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_on_q   <= lat_on_d;
      lat_note_q <= lat_note_d;
      lat_fcw_q  <= lat_fcw_d;
      vfcw_q     <= vfcw_d;
      vnote_q    <= vnote_d;
      vage_q     <= vage_d;
      gate_q     <= gate_d;
      trig_q     <= trig_d;
      steal_q    <= steal_d;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - randomized scoreboard bench for voice_allocator
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int FW = 32;
  localparam int AMAX = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ev_valid = 1'b0;
  logic              ev_ready;
  logic              ev_on = 1'b0;
  logic [6:0]        ev_note = '0;
  logic [FW-1:0]     ev_fcw = '0;
  logic [NV*FW-1:0]  voice_fcw;
  logic [NV-1:0]     voice_gate;
  logic [NV-1:0]     voice_trig;
  logic              steal;

  voice_allocator #(.NUM_VOICES(NV), .FCW_W(FW), .AGE_W(4)) dut (
    .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .ev_fcw(ev_fcw),
    .voice_fcw(voice_fcw), .voice_gate(voice_gate), .voice_trig(voice_trig),
    .steal(steal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NV*FW-1:0] fcw;
    logic [NV-1:0]    gate;
    logic [NV-1:0]    trig;
    logic             steal;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = -1;

  logic [FW-1:0] m_fcw  [NV];
  int            m_note [NV];
  bit            m_gate [NV];
  int            m_age  [NV];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [NV*FW-1:0] act, input logic [NV*FW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      m_fcw[i] = '0; m_note[i] = 0; m_gate[i] = 0; m_age[i] = 0;
    end
  endtask

  // Reference behaviour: apply one event to the voice table, return the resulting outputs
  task automatic model_event(input bit on, input int n, input logic [FW-1:0] f, output exp_t e);
    int tgt;
    e.trig  = '0;
    e.steal = 1'b0;
    if (on) begin
      tgt = -1;
      for (int i = 0; i < NV; i++) if (tgt < 0 && m_gate[i] && m_note[i] == n) tgt = i;
      for (int i = 0; i < NV; i++) if (tgt < 0 && !m_gate[i]) tgt = i;
      if (tgt < 0) begin
        e.steal = 1'b1;
        tgt = 0;
        for (int i = 1; i < NV; i++) if (m_age[i] > m_age[tgt]) tgt = i;
      end
      for (int i = 0; i < NV; i++) begin
        if (i == tgt) begin
          m_fcw[i] = f; m_note[i] = n; m_gate[i] = 1; m_age[i] = 0;
        end else if (m_gate[i]) begin
          m_age[i] = (m_age[i] >= AMAX) ? AMAX : m_age[i] + 1;
        end
      end
      e.trig[tgt] = 1'b1;
    end else begin
      for (int i = 0; i < NV; i++) if (m_gate[i] && m_note[i] == n) m_gate[i] = 0;
    end
    for (int i = 0; i < NV; i++) begin
      e.fcw[i*FW +: FW] = m_fcw[i];
      e.gate[i]         = m_gate[i];
    end
  endtask

  // Present an event and hold it until accepted; burst asserts the 2-cycle accept spacing
  task automatic send(input bit on, input int n, input logic [FW-1:0] f, input bit burst);
    int waitc = 0;
    bit ok = 1;
    exp_t e;
    ev_valid = 1'b1; ev_on = on; ev_note = 7'(n); ev_fcw = f;
    forever begin
      @(negedge clk);
      if (ev_ready && !reset) break;
      waitc++;
      if (waitc > 4) begin
        checks++; errors++; ok = 0;
        $display("FAIL accept_timeout: no accept after %0d cycles, expected within 4", waitc);
        break;
      end
    end
    if (ok) begin
      model_event(on, n, f, e);
      sb.push_back(e);
      if (burst && last_acc >= 0) chk("accept_gap", NV*FW'(cyc - last_acc), NV*FW'(2));
      last_acc = cyc;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    ev_valid = 1'b0;
    last_acc = -1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; ev_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    last_acc = -1;
  endtask

  // Monitor: pop and compare on each commit, otherwise pulses must be idle
  bit prev_ready = 1'b1;
  bit prev_reset = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (!prev_ready && ev_ready && !prev_reset) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_commit: output update with empty scoreboard at t=%0t", $time);
      end else begin
        e = sb.pop_front();
        chk("voice_fcw", voice_fcw, e.fcw);
        chk("voice_gate", NV*FW'(voice_gate), NV*FW'(e.gate));
        chk("voice_trig", NV*FW'(voice_trig), NV*FW'(e.trig));
        chk("steal", NV*FW'(steal), NV*FW'(e.steal));
      end
    end else begin
      chk("trig_idle", NV*FW'(voice_trig), '0);
      chk("steal_idle", NV*FW'(steal), '0);
    end
    prev_ready = ev_ready;
    prev_reset = reset;
  end

  initial begin
    exp_t dummy;
    model_clear();
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd60; ev_fcw = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; ev_valid = 1'b0;
    @(negedge clk);
    chk("reset_ready", NV*FW'(ev_ready), NV*FW'(1));
    chk("reset_gate", NV*FW'(voice_gate), '0);
    chk("reset_fcw", voice_fcw, '0);
    @(posedge clk); #1;

    send(1, 60, 32'h0100_0000, 0);
    @(negedge clk);
    chk("ready_low_decide", NV*FW'(ev_ready), '0);
    @(posedge clk); #1;
    idle(1);

    send(1, 62, 32'h0200_0000, 0);
    send(1, 64, 32'h0300_0000, 1);
    send(1, 65, 32'h0400_0000, 1);
    send(1, 67, 32'h0500_0000, 1);
    idle(2);

    do_reset();
    send(1, 60, 32'h0100_0000, 0);
    send(1, 62, 32'h0200_0000, 1);
    send(1, 60, 32'h0110_0000, 1);
    idle(1);
    send(0, 62, 32'hdead_beef, 0);
    idle(2);
    send(0, 99, 32'h0, 0);
    idle(2);

    do_reset();
    send(1, 60, 32'h0000_0001, 0);
    for (int k = 0; k < 18; k++) send(1, 70, 32'h0000_0000, 1);
    send(1, 72, 32'h0000_0003, 1);
    send(1, 74, 32'h0000_0004, 1);
    send(1, 76, 32'h0000_0005, 1);
    idle(2);

    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd80; ev_fcw = 32'hcafe_0000;
    @(negedge clk);
    chk("abort_ready", NV*FW'(ev_ready), NV*FW'(1));
    @(posedge clk); #1;
    reset = 1'b1; ev_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    last_acc = -1;
    @(negedge clk);
    chk("abort_ready_after", NV*FW'(ev_ready), NV*FW'(1));
    chk("abort_gate", NV*FW'(voice_gate), '0);
    chk("abort_trig", NV*FW'(voice_trig), '0);
    @(posedge clk); #1;

    for (int k = 0; k < 300; k++) begin
      bit burst;
      logic [FW-1:0] f;
      burst = ($urandom_range(0, 1) == 1);
      if (!burst) idle($urandom_range(0, 2));
      f = ($urandom_range(0, 7) == 0) ? '0 : FW'($urandom);
      send($urandom_range(0, 9) < 7, 60 + $urandom_range(0, 7), f, burst);
    end
    idle(1);

    for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", NV*FW'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES SHALL be: default 4; number of oscillator voices scheduled.
REQ-002 Parameter FCW_W SHALL be: default 32; frequency control word width, matching the oscillator fcw port.
REQ-003 Parameter AGE_W SHALL be: default 4; width of each per-voice age counter.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be synchronous, active-high reset.
REQ-006 ev_valid  input  1  SHALL indicate a note event is presented.
REQ-007 ev_ready  output  1  SHALL indicate the block accepts an event this cycle.
REQ-008 ev_on  input  1  SHALL select the event type: 1 = note-on, 0 = note-off.
REQ-009 ev_note  input  7  SHALL carry the note number.
REQ-010 ev_fcw  input  FCW_W  SHALL carry the fcw for a note-on; it is ignored for a note-off.
REQ-011 voice_fcw  output  NUM_VOICES*FCW_W  SHALL carry the per-voice fcw, with voice i at bits [i*FCW_W +: FCW_W].
REQ-012 voice_gate  output  NUM_VOICES  SHALL hold bit i high while voice i is held by a note.
REQ-013 voice_trig  output  NUM_VOICES  SHALL pulse bit i for one cycle when voice i is (re)assigned; it is used to clear the oscillator accumulator.
REQ-014 steal  output  1  SHALL pulse for one cycle when a note-on takes over an already-gated voice.

Function
REQ-015 The FSM SHALL have two states: IDLE and DECIDE; ev_ready SHALL equal (state == IDLE).
REQ-016 A handshake SHALL occur on a rising edge with ev_valid=1 and ev_ready=1; it SHALL latch ev_on, ev_note and ev_fcw and move the FSM to DECIDE.
REQ-017 DECIDE SHALL last exactly one cycle; on its ending edge the outputs SHALL update and the FSM SHALL return to IDLE, giving a throughput of one event per 2 cycles.
REQ-018 Output latency SHALL be: event accepted at edge k → voice_fcw, voice_gate, voice_trig and steal updated at edge k+1.
REQ-019 For a note-on, target selection SHALL use this priority:
- (a) the lowest-index voice with gate=1 and a stored note equal to ev_note (retrigger);
- (b) otherwise the lowest-index voice with gate=0;
- (c) otherwise the voice with the maximum age, ties going to the lowest index (steal).
REQ-020 On a note-on commit, the target voice SHALL get: fcw ← latched fcw, note ← latched note, gate ← 1, age ← 0, and trig bit pulsed.
REQ-021 On a note-on commit, every other voice with gate=1 SHALL have its age incremented, saturating at 2^AGE_W-1.
REQ-022 steal SHALL pulse only in case (c); a retrigger (case a) SHALL NOT assert steal.
REQ-023 For a note-off, every voice with gate=1 and a matching note SHALL get gate ← 0, with fcw, note and age retained; no trig SHALL be issued.
REQ-024 A note-off that matches no gated voice SHALL change nothing.
REQ-025 Voices with gate=0 SHALL keep their last fcw, so the oscillator continues running for its release.
REQ-026 voice_trig and steal SHALL be low in every cycle except the commit cycle.
REQ-027 ev_fcw=0 SHALL be treated as an ordinary value with no special case.

Reset
REQ-028 While reset=1, state SHALL be IDLE, and every voice SHALL have fcw=0, note=0, gate=0 and age=0.
REQ-029 While reset=1, voice_trig=0 and steal=0.
REQ-030 While reset=1, no handshake SHALL be registered, even if ev_valid=1.
REQ-031 Reset asserted while in DECIDE SHALL discard the pending event, with no output update from it.
REQ-032 ev_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-033 Reset then note-on 60/fcw 0x0100_0000 → at edge k+1, voice0 fcw=0x0100_0000, gate=0001, trig=0001, steal=0; ev_ready low for exactly 1 cycle.
REQ-034 Note-ons 60, 62, 64, 65, then note-on 67 → voices 0–3 gated in order; the 5th steals voice0 (age 3, oldest), with steal=1, trig=0001, voice0 note=67.
REQ-035 Voices 0–1 hold 60 and 62; note-on 60 with a new fcw → voice0 retriggered (trig=0001, fcw updated), steal=0, voice1 age incremented.
REQ-036 Note-off 62 with voice1 gated → gate bit1 cleared, fcw1 unchanged; a later note-off 99 → no output change.
REQ-037 ev_valid held high continuously with back-to-back events → exactly one accept every 2 cycles, no event lost or duplicated.
REQ-038 Reset asserted in the DECIDE cycle of a note-on → all gates=0, no trig pulse, and ev_ready=1 after reset deasserts.
